trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/trigger_capture.sv | 158 +++++++++++++++
 tb/tb_trigger_capture.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// Pre/post-trigger capture buffer: keeps PRE samples before a level crossing and fills the rest after it.
// Optional macro AUTO_TRIG_EN forces a trigger after AUTO_TO valid samples waiting in WAIT.
module trigger_capture #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int PRE     = 128,
  parameter int AUTO_TO = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic          arm,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          trig_auto
);

  localparam int              DEPTH     = 2**AW;
  localparam int              POST_N    = DEPTH - PRE - 1;
  localparam logic [AW-1:0]   PRE_A     = AW'(PRE);
  localparam logic [AW:0]     PRE_LAST  = (AW+1)'(PRE - 1);
  localparam logic [AW:0]     POST_LAST = (AW+1)'(POST_N - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] trig_addr_reg;
  logic [AW:0]   cnt_reg;
  logic [DW-1:0] prev_reg;
  logic          prev_valid_reg;
  logic          trig_auto_reg;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [DW-1:0] rd_data_reg;
  logic          capturing, we, rise_hit, fall_hit, real_trig, auto_hit, trig_hit;
  logic [AW-1:0] rd_ptr;

  assign capturing = (state_reg == S_PRE) || (state_reg == S_WAIT) || (state_reg == S_POST);
  // An arm cycle restarts the capture, so its sample is not stored.
  assign we        = capturing && sample_valid && !arm;
  assign rise_hit  = prev_valid_reg && (prev_reg < trig_level) && (sample_in >= trig_level);
  assign fall_hit  = prev_valid_reg && (prev_reg > trig_level) && (sample_in <= trig_level);
  assign real_trig = (state_reg == S_WAIT) && we && (trig_slope ? fall_hit : rise_hit);

`ifdef AUTO_TRIG_EN
  localparam int WCW = $clog2(AUTO_TO + 1);
  logic [WCW-1:0] wait_cnt_reg;

  assign auto_hit = (state_reg == S_WAIT) && we && (wait_cnt_reg == WCW'(AUTO_TO - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
    end else if (arm) begin
      wait_cnt_reg <= '0;
    end else if ((state_reg == S_WAIT) && we) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  assign auto_hit = 1'b0;
`endif

  assign trig_hit = real_trig || auto_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (arm) begin
      state_next = S_PRE;
    end else begin
      case (state_reg)
        S_PRE:   if (we && (cnt_reg == PRE_LAST))  state_next = S_WAIT;
        S_WAIT:  if (trig_hit)                     state_next = S_POST;
        S_POST:  if (we && (cnt_reg == POST_LAST)) state_next = S_DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    busy_next = (state_next == S_PRE) || (state_next == S_WAIT) || (state_next == S_POST);
    done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      trig_addr_reg  <= '0;
      cnt_reg        <= '0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      trig_auto_reg  <= 1'b0;
    end else if (arm) begin
      wr_ptr_reg     <= '0;
      cnt_reg        <= '0;
      prev_valid_reg <= 1'b0;
      trig_auto_reg  <= 1'b0;
    end else if (we) begin
      wr_ptr_reg     <= wr_ptr_reg + 1'b1;
      prev_reg       <= sample_in;
      prev_valid_reg <= 1'b1;
      case (state_reg)
        S_PRE:   cnt_reg <= (cnt_reg == PRE_LAST) ? '0 : cnt_reg + 1'b1;
        S_WAIT: begin
          if (trig_hit) begin
            trig_addr_reg <= wr_ptr_reg;
            cnt_reg       <= '0;
            trig_auto_reg <= auto_hit && !real_trig;
          end
        end
        S_POST:  cnt_reg <= cnt_reg + 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr_reg] <= sample_in;
    end
  end

  // Read index is relative to the oldest retained sample; wraps naturally in AW bits.
  assign rd_ptr = trig_addr_reg - PRE_A + rd_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_ptr];
    end
  end

  assign rd_data   = rd_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign trig_auto = trig_auto_reg;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: ramp captures, sparse valid, reset and re-arm mid-capture.
// Auto-trigger expectations follow the AUTO_TRIG_EN macro.
module tb_trigger_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic [7:0] trig_level = '0;
  logic       trig_slope = 1'b0;
  logic       arm = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       busy, done, trig_auto;

  int n_cmp = 0;
  int n_err = 0;

  trigger_capture dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .trig_auto(trig_auto)
  );

  always #5 clk = ~clk;

  // Arm, then stream a ramp (step per valid sample) until done or maxs samples.
  task automatic do_capture(input logic [7:0] first, input int step, input int gap,
                            input int maxs, output int nvalid, output int ncyc);
    logic [7:0] v;
    v = first;
    @(negedge clk); arm = 1'b1; sample_valid = 1'b0;
    @(negedge clk); arm = 1'b0;
    nvalid = 0; ncyc = 0;
    while (!done && nvalid < maxs) begin
      sample_in    = v;
      sample_valid = ((ncyc % gap) == 0);
      @(negedge clk);
      ncyc++;
      if (sample_valid) begin
        nvalid++;
        v = v + 8'(step);
      end
      sample_valid = 1'b0;
    end
    sample_valid = 1'b0;
  endtask

  task automatic read_at(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk); rd_addr = a;
    @(negedge clk); d = rd_data;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (trig_auto !== 1'b0) begin n_err++; $display("FAIL reset_trig_auto: got %0b want 0", trig_auto); end
    n_cmp++; if (rd_data !== 8'd0)   begin n_err++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_rising;
    int nv, nc; logic [7:0] d;
    trig_level = 8'd100; trig_slope = 1'b0;
    do_capture(8'd228, 1, 1, 2000, nv, nc);
    n_cmp++; if (nv !== 256)        begin n_err++; $display("FAIL rise_samples: got %0d want 256", nv); end
    n_cmp++; if (done !== 1'b1)     begin n_err++; $display("FAIL rise_done: got %0b want 1", done); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rise_busy: got %0b want 0", busy); end
    n_cmp++; if (trig_auto !== 1'b0) begin n_err++; $display("FAIL rise_trig_auto: got %0b want 0", trig_auto); end
    read_at(8'd128, d);
    n_cmp++; if (d !== 8'd100) begin n_err++; $display("FAIL rise_rd128: got %0d want 100", d); end
    read_at(8'd0, d);
    n_cmp++; if (d !== 8'd228) begin n_err++; $display("FAIL rise_rd0: got %0d want 228", d); end
    read_at(8'd255, d);
    n_cmp++; if (d !== 8'd227) begin n_err++; $display("FAIL rise_rd255: got %0d want 227", d); end
    $display("test_rising: %0d samples", nv);
  endtask

  task automatic test_falling;
    int nv, nc; logic [7:0] d;
    trig_level = 8'd60; trig_slope = 1'b1;
    do_capture(8'd188, -1, 1, 2000, nv, nc);
    n_cmp++; if (nv !== 256) begin n_err++; $display("FAIL fall_samples: got %0d want 256", nv); end
    read_at(8'd128, d);
    n_cmp++; if (d !== 8'd60)  begin n_err++; $display("FAIL fall_rd128: got %0d want 60", d); end
    read_at(8'd127, d);
    n_cmp++; if (d !== 8'd61)  begin n_err++; $display("FAIL fall_rd127: got %0d want 61", d); end
    read_at(8'd0, d);
    n_cmp++; if (d !== 8'd188) begin n_err++; $display("FAIL fall_rd0: got %0d want 188", d); end
    $display("test_falling: %0d samples", nv);
  endtask

  task automatic test_sparse;
    int nv, nc; logic [7:0] d;
    trig_level = 8'd100; trig_slope = 1'b0;
    do_capture(8'd228, 1, 4, 2000, nv, nc);
    n_cmp++; if (nv !== 256)  begin n_err++; $display("FAIL sparse_samples: got %0d want 256", nv); end
    n_cmp++; if (nc !== 1021) begin n_err++; $display("FAIL sparse_cycles: got %0d want 1021", nc); end
    read_at(8'd128, d);
    n_cmp++; if (d !== 8'd100) begin n_err++; $display("FAIL sparse_rd128: got %0d want 100", d); end
    read_at(8'd0, d);
    n_cmp++; if (d !== 8'd228) begin n_err++; $display("FAIL sparse_rd0: got %0d want 228", d); end
    read_at(8'd255, d);
    n_cmp++; if (d !== 8'd227) begin n_err++; $display("FAIL sparse_rd255: got %0d want 227", d); end
    $display("test_sparse: %0d samples in %0d cycles", nv, nc);
  endtask

  // Crossing at sample 100 lands inside PRE and must be ignored; next crossing after wrap triggers.
  task automatic test_pre_ignore;
    int nv, nc; logic [7:0] d;
    trig_level = 8'd100; trig_slope = 1'b0;
    do_capture(8'd0, 1, 1, 2000, nv, nc);
    n_cmp++; if (nv !== 484) begin n_err++; $display("FAIL preign_samples: got %0d want 484", nv); end
    read_at(8'd128, d);
    n_cmp++; if (d !== 8'd100) begin n_err++; $display("FAIL preign_rd128: got %0d want 100", d); end
    read_at(8'd0, d);
    n_cmp++; if (d !== 8'd228) begin n_err++; $display("FAIL preign_rd0: got %0d want 228", d); end
    $display("test_pre_ignore: %0d samples", nv);
  endtask

  task automatic test_reset_mid_post;
    int nv, nc; logic [7:0] d;
    trig_level = 8'd100; trig_slope = 1'b0;
    do_capture(8'd228, 1, 1, 200, nv, nc);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midpost_busy_before: got %0b want 1", busy); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midpost_busy_async: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midpost_done_async: got %0b want 0", done); end
    @(negedge clk); rst = 1'b1;
    sample_valid = 1'b1;
    repeat (3) @(negedge clk);
    sample_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midpost_idle_busy: got %0b want 0", busy); end
    do_capture(8'd228, 1, 1, 2000, nv, nc);
    n_cmp++; if (nv !== 256) begin n_err++; $display("FAIL midpost_rearm_samples: got %0d want 256", nv); end
    read_at(8'd128, d);
    n_cmp++; if (d !== 8'd100) begin n_err++; $display("FAIL midpost_rd128: got %0d want 100", d); end
    $display("test_reset_mid_post: re-armed capture %0d samples", nv);
  endtask

  task automatic test_rearm_in_post;
    int nv, nc; logic [7:0] d;
    trig_level = 8'd100; trig_slope = 1'b0;
    do_capture(8'd228, 1, 1, 200, nv, nc);
    do_capture(8'd228, 1, 1, 2000, nv, nc);
    n_cmp++; if (nv !== 256)    begin n_err++; $display("FAIL rearm_samples: got %0d want 256", nv); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rearm_done: got %0b want 1", done); end
    read_at(8'd255, d);
    n_cmp++; if (d !== 8'd227) begin n_err++; $display("FAIL rearm_rd255: got %0d want 227", d); end
    $display("test_rearm_in_post: %0d samples", nv);
  endtask

  task automatic test_auto;
    int nv, nc;
    trig_level = 8'd100; trig_slope = 1'b0;
`ifdef AUTO_TRIG_EN
    do_capture(8'd50, 0, 1, 3000, nv, nc);
    n_cmp++; if (nv !== 1279)        begin n_err++; $display("FAIL auto_samples: got %0d want 1279", nv); end
    n_cmp++; if (done !== 1'b1)      begin n_err++; $display("FAIL auto_done: got %0b want 1", done); end
    n_cmp++; if (trig_auto !== 1'b1) begin n_err++; $display("FAIL auto_flag: got %0b want 1", trig_auto); end
`else
    do_capture(8'd50, 0, 1, 1500, nv, nc);
    n_cmp++; if (nv !== 1500)        begin n_err++; $display("FAIL noauto_samples: got %0d want 1500", nv); end
    n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL noauto_busy: got %0b want 1", busy); end
    n_cmp++; if (trig_auto !== 1'b0) begin n_err++; $display("FAIL noauto_flag: got %0b want 0", trig_auto); end
`endif
    $display("test_auto: %0d samples", nv);
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_sparse();
    test_pre_ignore();
    test_reset_mid_post();
    test_rearm_in_post();
    test_auto();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
